exu_result_pipe: RTL and testbench

- Parametrised in-flight result pipeline for the execution unit. It replaces the fixed EX2/EX3/WB register chain with DEPTH stages of LANES slots each.
- Provides a priority forwarding lookup for NSRC operand ports.
- Captures late results (loads), including while the pipeline is stalled.
- Drives register-file writeback from the last stage.

---
 rtl/exu_result_pipe_if.sv | 36 +++
 rtl/exu_result_pipe.sv | 161 ++++++++++++++++
 tb/tb_exu_result_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_result_pipe_if.sv
// rtl/exu_result_pipe_if.sv - Issue, late-result, forwarding and writeback signals of the result pipeline
interface exu_result_pipe_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int NSRC  = 4
);
    logic                  stall;
    logic                  kill;
    logic [LANES-1:0]      in_valid;
    logic [LANES-1:0]      in_rd_en;
    logic [LANES*5-1:0]    in_rd_addr;
    logic [LANES-1:0]      in_late;
    logic [LANES*XLEN-1:0] in_rd_val;
    logic                  late_valid;
    logic [XLEN-1:0]       late_data;
    logic [NSRC*5-1:0]     src_addr;
    logic [NSRC-1:0]       fwd_hit;
    logic [NSRC-1:0]       fwd_ready;
    logic [NSRC*XLEN-1:0]  fwd_val;
    logic                  late_wait;
    logic [LANES-1:0]      wb_valid;
    logic [LANES*5-1:0]    wb_addr;
    logic [LANES*XLEN-1:0] wb_val;

    modport master (
        output stall, kill, in_valid, in_rd_en, in_rd_addr, in_late, in_rd_val,
        output late_valid, late_data, src_addr,
        input  fwd_hit, fwd_ready, fwd_val, late_wait, wb_valid, wb_addr, wb_val
    );

    modport slave (
        input  stall, kill, in_valid, in_rd_en, in_rd_addr, in_late, in_rd_val,
        input  late_valid, late_data, src_addr,
        output fwd_hit, fwd_ready, fwd_val, late_wait, wb_valid, wb_addr, wb_val
    );
endinterface

// File: rtl/exu_result_pipe.sv
// rtl/exu_result_pipe.sv - In-flight result stages with priority forwarding, late-result capture and writeback
module exu_result_pipe #(
    parameter int LANES      = 2,
    parameter int DEPTH      = 3,
    parameter int XLEN       = 32,
    parameter int NSRC       = 4,
    parameter int LATE_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    exu_result_pipe_if.slave bus
);

    logic [LANES-1:0] s_valid [DEPTH];
    logic [LANES-1:0] s_pend  [DEPTH];
    logic [LANES-1:0] s_rd_en [DEPTH];
    logic [4:0]       s_addr  [DEPTH][LANES];
    logic [XLEN-1:0]  s_val   [DEPTH][LANES];

    logic [LANES-1:0] tgt_hot [DEPTH];
    logic [LANES-1:0] cap     [DEPTH];
    logic             late_wait;
    logic             advance;
    logic             wb_en;

    assign late_wait = |(s_valid[DEPTH-1] & s_pend[DEPTH-1]);
    assign advance   = !bus.stall && !late_wait;
    assign wb_en     = !rst && !bus.stall && !bus.kill && !late_wait;

    // Oldest pending slot at or above LATE_STAGE: highest stage first, lane 0 first within a stage.
    always_comb begin
        logic found;
        found = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            tgt_hot[s] = '0;
        end
        for (int s = DEPTH - 1; s >= LATE_STAGE; s--) begin
            for (int l = 0; l < LANES; l++) begin
                if (!found && s_valid[s][l] && s_pend[s][l]) begin
                    tgt_hot[s][l] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            cap[s] = tgt_hot[s] & {LANES{bus.late_valid}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.kill) begin
            for (int s = 0; s < DEPTH; s++) begin
                s_valid[s] <= '0;
                s_pend[s]  <= '0;
            end
        end else if (advance) begin
            s_valid[0] <= bus.in_valid;
            s_pend[0]  <= bus.in_valid & bus.in_late & bus.in_rd_en;
            for (int s = 1; s < DEPTH; s++) begin
                s_valid[s] <= s_valid[s-1];
                s_pend[s]  <= s_pend[s-1] & ~cap[s-1];
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                s_pend[s] <= s_pend[s] & ~cap[s];
            end
        end
    end

    // Payload carries no reset; a captured late value follows its slot when the pipe advances.
    always_ff @(posedge clk) begin
        if (advance) begin
            s_rd_en[0] <= bus.in_rd_en;
            for (int l = 0; l < LANES; l++) begin
                s_addr[0][l] <= bus.in_rd_addr[l*5 +: 5];
                s_val[0][l]  <= bus.in_rd_val[l*XLEN +: XLEN];
            end
            for (int s = 1; s < DEPTH; s++) begin
                s_rd_en[s] <= s_rd_en[s-1];
                for (int l = 0; l < LANES; l++) begin
                    s_addr[s][l] <= s_addr[s-1][l];
                    s_val[s][l]  <= cap[s-1][l] ? bus.late_data : s_val[s-1][l];
                end
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (cap[s][l]) begin
                        s_val[s][l] <= bus.late_data;
                    end
                end
            end
        end
    end

    logic [NSRC-1:0]      fwd_hit;
    logic [NSRC-1:0]      fwd_ready;
    logic [NSRC*XLEN-1:0] fwd_val;

    // Scan oldest to youngest so the last match, the youngest producer, wins.
    always_comb begin
        fwd_hit   = '0;
        fwd_ready = '0;
        fwd_val   = '0;
        for (int p = 0; p < NSRC; p++) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    if (s_valid[s][l] && s_rd_en[s][l] &&
                        bus.src_addr[p*5 +: 5] != 5'd0 &&
                        s_addr[s][l] == bus.src_addr[p*5 +: 5]) begin
                        fwd_hit[p]               = 1'b1;
                        fwd_ready[p]             = !s_pend[s][l] || cap[s][l];
                        fwd_val[p*XLEN +: XLEN]  = cap[s][l] ? bus.late_data : s_val[s][l];
                    end
                end
            end
        end
    end

    logic [LANES-1:0]      wb_valid;
    logic [LANES*5-1:0]    wb_addr;
    logic [LANES*XLEN-1:0] wb_val;

    always_comb begin
        wb_valid = '0;
        wb_addr  = '0;
        wb_val   = '0;
        for (int l = 0; l < LANES; l++) begin
            wb_valid[l] = wb_en && s_valid[DEPTH-1][l] && s_rd_en[DEPTH-1][l] && !s_pend[DEPTH-1][l];
            if (wb_valid[l]) begin
                wb_addr[l*5 +: 5]       = s_addr[DEPTH-1][l];
                wb_val[l*XLEN +: XLEN]  = s_val[DEPTH-1][l];
            end
        end
    end

    assign bus.fwd_hit   = fwd_hit;
    assign bus.fwd_ready = fwd_ready;
    assign bus.fwd_val   = fwd_val;
    assign bus.late_wait = late_wait;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_addr   = wb_addr;
    assign bus.wb_val    = wb_val;

    // Only one load may be waiting in the capture window at a time.
    logic [DEPTH*LANES-1:0] pend_hi;
    always_comb begin
        pend_hi = '0;
        for (int s = LATE_STAGE; s < DEPTH; s++) begin
            for (int l = 0; l < LANES; l++) begin
                pend_hi[s*LANES + l] = s_valid[s][l] && s_pend[s][l];
            end
        end
    end

    a_single_late: assert property (@(posedge clk) disable iff (rst) $countones(pend_hi) <= 1);

endmodule

// File: tb/tb_exu_result_pipe.sv
// tb/tb_exu_result_pipe.sv - Scoreboard bench for exu_result_pipe with directed vectors
module tb_exu_result_pipe;
    localparam int LANES = 2;
    localparam int DEPTH = 3;
    localparam int XLEN  = 32;
    localparam int NSRC  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exu_result_pipe_if #(.LANES(LANES), .XLEN(XLEN), .NSRC(NSRC)) bus ();

    exu_result_pipe #(
        .LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN), .NSRC(NSRC), .LATE_STAGE(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          lane;
        logic [4:0]  addr;
        logic [31:0] val;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_fwd(input string name, input int p, input logic h, input logic r, input logic [31:0] v);
        logic [33:0] act;
        logic [33:0] exp;
        act = {bus.fwd_hit[p], bus.fwd_ready[p], bus.fwd_val[p*XLEN +: XLEN]};
        exp = {h, r, v};
        if (h && !r) begin
            act[31:0] = '0;
            exp[31:0] = '0;
        end
        chk(name, 64'(act), 64'(exp));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.wb_valid[l]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL wb_unexpected: lane %0d got x%0d=%0h expected no write",
                                 l, bus.wb_addr[l*5 +: 5], bus.wb_val[l*XLEN +: XLEN]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.lane != l || mon_e.addr != bus.wb_addr[l*5 +: 5] ||
                            mon_e.val != bus.wb_val[l*XLEN +: XLEN]) begin
                            errors++;
                            $display("FAIL wb_data: got lane %0d x%0d=%0h expected lane %0d x%0d=%0h",
                                     l, bus.wb_addr[l*5 +: 5], bus.wb_val[l*XLEN +: XLEN],
                                     mon_e.lane, mon_e.addr, mon_e.val);
                        end
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_in();
        bus.stall      = 1'b0;
        bus.kill       = 1'b0;
        bus.in_valid   = '0;
        bus.in_rd_en   = '0;
        bus.in_rd_addr = '0;
        bus.in_late    = '0;
        bus.in_rd_val  = '0;
        bus.late_valid = 1'b0;
        bus.late_data  = '0;
    endtask

    task automatic set_src(input int p, input logic [4:0] a);
        bus.src_addr[p*5 +: 5] = a;
    endtask

    task automatic put(input int l, input logic [4:0] rd, input logic [31:0] v, input logic late, input logic en);
        bus.in_valid[l]              = 1'b1;
        bus.in_rd_en[l]              = en;
        bus.in_rd_addr[l*5 +: 5]     = rd;
        bus.in_rd_val[l*XLEN +: XLEN] = v;
        bus.in_late[l]               = late;
    endtask

    task automatic push_exp(input int l, input logic [4:0] rd, input logic [31:0] v);
        wb_t e;
        e.lane = l;
        e.addr = rd;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int l, input logic [4:0] rd, input logic [31:0] v);
        put(l, rd, v, 1'b0, 1'b1);
        push_exp(l, rd, v);
    endtask

    task automatic issue_late(input int l, input logic [4:0] rd, input logic [31:0] final_v);
        put(l, rd, 32'h0, 1'b1, 1'b1);
        push_exp(l, rd, final_v);
    endtask

    initial begin
        clear_in();
        bus.src_addr = '0;
        rst = 1'b1;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        settle();
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_addr", bus.wb_addr, 0);
        chk("rst_fwd_hit", bus.fwd_hit, 0);
        chk("rst_late_wait", bus.late_wait, 0);

        // Single entry: forwarded in cycles 1..3, written back in cycle 3
        set_src(0, 5'd5);
        issue(0, 5'd5, 32'h11);
        settle();
        chk_fwd("t1_c0", 0, 0, 0, 0);
        cyc(); clear_in(); settle();
        chk_fwd("t1_c1", 0, 1, 1, 32'h11);
        chk("t1_wb_c1", bus.wb_valid, 0);
        cyc(); settle();
        chk_fwd("t1_c2", 0, 1, 1, 32'h11);
        chk("t1_wb_c2", bus.wb_valid, 0);
        cyc(); settle();
        chk_fwd("t1_c3", 0, 1, 1, 32'h11);
        chk("t1_wb_c3", bus.wb_valid, 2'b01);
        chk("t1_wb_addr", bus.wb_addr, 10'd5);
        chk("t1_wb_val", bus.wb_val, 64'h11);
        cyc(); settle();
        chk_fwd("t1_c4", 0, 0, 0, 0);

        // Priority: youngest stage, higher lane wins; x0 and rd_en=0 never hit
        set_src(0, 5'd7); set_src(1, 5'd0); set_src(2, 5'd8); set_src(3, 5'd3);
        issue(0, 5'd7, 32'hC);
        cyc(); clear_in();
        issue(0, 5'd0, 32'h99);
        put(1, 5'd8, 32'hEE, 1'b0, 1'b0);
        cyc(); clear_in();
        issue(0, 5'd7, 32'hA);
        issue(1, 5'd7, 32'hB);
        settle();
        chk_fwd("t2_x7_old", 0, 1, 1, 32'hC);
        chk_fwd("t2_x8_noen_a", 2, 0, 0, 0);
        cyc(); clear_in(); settle();
        chk_fwd("t2_x7_prio", 0, 1, 1, 32'hB);
        chk_fwd("t2_x0", 1, 0, 0, 0);
        chk_fwd("t2_x8_noen_b", 2, 0, 0, 0);
        chk_fwd("t2_x3_miss", 3, 0, 0, 0);
        cyc(); settle();
        chk_fwd("t2_x7_s1", 0, 1, 1, 32'hB);
        cyc(); settle();
        chk("t2_wb_both", bus.wb_valid, 2'b11);
        cyc(); cyc();

        // Late load reaching the last stage holds the pipe until delivery
        set_src(0, 5'd9); set_src(1, 5'd10);
        issue_late(1, 5'd9, 32'hDEAD);
        cyc(); clear_in(); settle();
        chk_fwd("t3_pend_s0", 0, 1, 0, 0);
        cyc(); settle();
        chk("t3_lw_s1", bus.late_wait, 0);
        cyc(); settle();
        chk("t3_lw_s2", bus.late_wait, 1);
        chk_fwd("t3_pend_s2", 0, 1, 0, 0);
        issue(0, 5'd10, 32'h10);
        settle();
        chk("t3_wb_hold_a", bus.wb_valid, 0);
        cyc(); settle();
        chk("t3_lw_hold", bus.late_wait, 1);
        chk("t3_wb_hold_b", bus.wb_valid, 0);
        chk_fwd("t3_x10_held", 1, 0, 0, 0);
        cyc();
        bus.late_valid = 1'b1;
        bus.late_data  = 32'hDEAD;
        settle();
        chk_fwd("t3_bypass", 0, 1, 1, 32'hDEAD);
        chk("t3_wb_cap", bus.wb_valid, 0);
        cyc();
        bus.late_valid = 1'b0;
        bus.late_data  = '0;
        settle();
        chk("t3_lw_clear", bus.late_wait, 0);
        chk("t3_wb_lane1", bus.wb_valid, 2'b10);
        chk_fwd("t3_x9_cap", 0, 1, 1, 32'hDEAD);
        cyc(); clear_in(); settle();
        chk_fwd("t3_x10_s0", 1, 1, 1, 32'h10);
        chk_fwd("t3_x9_gone", 0, 0, 0, 0);
        cyc(); cyc(); cyc();

        // Early delivery: ignored in stage 0, captured in stage 1 while advancing
        set_src(0, 5'd11);
        issue_late(0, 5'd11, 32'h1234);
        cyc(); clear_in();
        bus.late_valid = 1'b1;
        bus.late_data  = 32'hBAD;
        settle();
        chk_fwd("t4_s0_ignored", 0, 1, 0, 0);
        cyc();
        bus.late_data = 32'h1234;
        settle();
        chk_fwd("t4_s1_bypass", 0, 1, 1, 32'h1234);
        cyc();
        bus.late_valid = 1'b0;
        bus.late_data  = '0;
        settle();
        chk("t4_no_wait", bus.late_wait, 0);
        chk_fwd("t4_s2_ready", 0, 1, 1, 32'h1234);
        chk("t4_wb", bus.wb_valid, 2'b01);
        cyc(); cyc();

        // Stall with all stages occupied
        set_src(0, 5'd12); set_src(1, 5'd15); set_src(2, 5'd16); set_src(3, 5'd14);
        issue(0, 5'd12, 32'h120);
        issue(1, 5'd13, 32'h130);
        cyc(); clear_in();
        issue(0, 5'd14, 32'h140);
        cyc(); clear_in();
        issue(1, 5'd15, 32'h150);
        cyc(); clear_in();
        bus.stall = 1'b1;
        put(0, 5'd16, 32'h160, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t5_stall_wb", bus.wb_valid, 0);
            chk_fwd("t5_stall_x12", 0, 1, 1, 32'h120);
            chk_fwd("t5_stall_x15", 1, 1, 1, 32'h150);
            chk_fwd("t5_stall_x16", 2, 0, 0, 0);
            chk_fwd("t5_stall_x14", 3, 1, 1, 32'h140);
            cyc();
        end
        clear_in();
        settle();
        chk("t5_rel_wb0", bus.wb_valid, 2'b11);
        cyc(); settle();
        chk("t5_rel_wb1", bus.wb_valid, 2'b01);
        cyc(); settle();
        chk("t5_rel_wb2", bus.wb_valid, 2'b10);
        cyc(); settle();
        chk("t5_rel_wb3", bus.wb_valid, 0);
        chk_fwd("t5_x16_dropped", 2, 0, 0, 0);
        cyc();

        // Kill with six entries in flight plus two incoming
        set_src(0, 5'd1); set_src(1, 5'd4); set_src(2, 5'd17); set_src(3, 5'd18);
        put(0, 5'd1, 32'h101, 1'b0, 1'b1); put(1, 5'd2, 32'h102, 1'b0, 1'b1);
        cyc(); clear_in();
        put(0, 5'd3, 32'h103, 1'b0, 1'b1); put(1, 5'd4, 32'h104, 1'b0, 1'b1);
        cyc(); clear_in();
        put(0, 5'd6, 32'h106, 1'b0, 1'b1); put(1, 5'd17, 32'h117, 1'b0, 1'b1);
        cyc(); clear_in();
        put(0, 5'd18, 32'h118, 1'b0, 1'b1); put(1, 5'd19, 32'h119, 1'b0, 1'b1);
        bus.kill = 1'b1;
        settle();
        chk("t6_kill_wb", bus.wb_valid, 0);
        chk_fwd("t6_kill_x1_live", 0, 1, 1, 32'h101);
        cyc(); clear_in(); settle();
        chk_fwd("t6_x1", 0, 0, 0, 0);
        chk_fwd("t6_x4", 1, 0, 0, 0);
        chk_fwd("t6_x17", 2, 0, 0, 0);
        chk_fwd("t6_x18", 3, 0, 0, 0);
        chk("t6_wb_after", bus.wb_valid, 0);
        cyc(); cyc();

        // Reset mid-stream clears the same way
        set_src(0, 5'd20); set_src(1, 5'd23); set_src(2, 5'd25); set_src(3, 5'd27);
        put(0, 5'd20, 32'h120, 1'b0, 1'b1); put(1, 5'd21, 32'h121, 1'b0, 1'b1);
        cyc(); clear_in();
        put(0, 5'd22, 32'h122, 1'b0, 1'b1); put(1, 5'd23, 32'h123, 1'b0, 1'b1);
        cyc(); clear_in();
        put(0, 5'd24, 32'h124, 1'b0, 1'b1); put(1, 5'd25, 32'h125, 1'b0, 1'b1);
        cyc(); clear_in();
        put(0, 5'd27, 32'h127, 1'b0, 1'b1); put(1, 5'd28, 32'h128, 1'b0, 1'b1);
        rst = 1'b1;
        settle();
        chk("t7_rst_wb", bus.wb_valid, 0);
        cyc();
        rst = 1'b0;
        clear_in();
        settle();
        chk_fwd("t7_x20", 0, 0, 0, 0);
        chk_fwd("t7_x23", 1, 0, 0, 0);
        chk_fwd("t7_x25", 2, 0, 0, 0);
        chk_fwd("t7_x27", 3, 0, 0, 0);
        chk("t7_wb_after", bus.wb_valid, 0);
        chk("t7_lw_after", bus.late_wait, 0);

        // Pipeline still works after the mid-stream reset
        issue(1, 5'd26, 32'h260);
        cyc(); clear_in();
        cyc(); cyc(); settle();
        chk("t8_wb", bus.wb_valid, 2'b10);
        cyc(); cyc(); settle();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
